// File: rtl/tlul_mem_responder.sv
// tlul_mem_responder: TL-UL device with a word-addressed memory, one transaction at a time.
// Optional feature macro: TLUL_MEM_PARTIAL_EN (PutPartialData with arbitrary byte masks).
package tlul_pkg;
   localparam logic [2:0] PutFullData    = 3'h0;
   localparam logic [2:0] PutPartialData = 3'h1;
   localparam logic [2:0] Get            = 3'h4;
   localparam logic [2:0] AccessAck      = 3'h0;
   localparam logic [2:0] AccessAckData  = 3'h1;

   localparam logic [13:0] TL_D_USER_DEFAULT = 14'h0;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic [0:0]  d_sink;
      logic [31:0] d_data;
      logic [13:0] d_user;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

   localparam tl_d2h_t TL_D2H_DEFAULT = '{
      d_valid: 1'b0, d_opcode: AccessAck, d_param: 3'h0, d_size: 2'h0,
      d_source: 8'h0, d_sink: 1'b0, d_data: 32'h0, d_user: TL_D_USER_DEFAULT,
      d_error: 1'b0, a_ready: 1'b1};
endpackage

// A beat transfers on a channel when its valid and ready are both high at a rising
// edge; valid never waits on ready, and D-channel fields hold while d_valid && !d_ready.
module tlul_mem_responder
   import tlul_pkg::*;
#(
   parameter int Depth      = 1024,
   parameter int WaitCycles = 0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  tl_h2d_t    tl_i,
   output tl_d2h_t    tl_o,
   output logic [1:0] dbg_state
);
   localparam int IdxW = $clog2(Depth);
   localparam int AddrW = IdxW + 2;
   localparam logic [31:0] AddrHiMask = ~((32'd1 << AddrW) - 32'd1);
   localparam logic [3:0] WaitLoad = (WaitCycles > 0) ? 4'(WaitCycles - 1) : 4'd0;

   typedef enum logic [1:0] {StIdle = 2'd0, StWait = 2'd1, StResp = 2'd2} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        a_ready_q;
   logic [2:0]  rsp_opcode_q;
   logic [1:0]  rsp_size_q;
   logic [7:0]  rsp_source_q;
   logic [31:0] rsp_data_q;
   logic        rsp_error_q;

   logic [31:0] mem [Depth];

   logic            is_get, is_full, is_part;
   logic            addr_err, size_err, align_err, op_err, mask_err, part_err, req_err;
   logic [3:0]      full_mask;
   logic            accept, wr_en;
   logic [IdxW-1:0] word_idx;

   assign is_get   = (tl_i.a_opcode == Get);
   assign is_full  = (tl_i.a_opcode == PutFullData);
   assign is_part  = (tl_i.a_opcode == PutPartialData);
   assign word_idx = tl_i.a_address[AddrW-1:2];

   always_comb begin
      full_mask = 4'hF;
      case (tl_i.a_size)
         2'd0:    full_mask = 4'b0001 << tl_i.a_address[1:0];
         2'd1:    full_mask = 4'b0011 << tl_i.a_address[1:0];
         default: full_mask = 4'hF;
      endcase
   end

   assign addr_err  = |(tl_i.a_address & AddrHiMask);
   assign size_err  = (tl_i.a_size > 2'd2);
   assign align_err = ((tl_i.a_size == 2'd1) && tl_i.a_address[0]) ||
                      ((tl_i.a_size == 2'd2) && (|tl_i.a_address[1:0]));
   assign op_err    = !(is_get || is_full || is_part);
   assign mask_err  = is_full && (tl_i.a_mask != full_mask);
`ifdef TLUL_MEM_PARTIAL_EN
   assign part_err  = 1'b0;
`else
   assign part_err  = is_part;
`endif
   assign req_err = addr_err | size_err | align_err | op_err | mask_err | part_err;

   // a_ready_q is only ever high in StIdle, so it alone qualifies the accept edge.
   assign accept = tl_i.a_valid && a_ready_q;
   assign wr_en  = accept && !req_err && (is_full || is_part);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               if (WaitCycles > 0) begin
                  state_d = StWait;
                  cnt_d   = WaitLoad;
               end else begin
                  state_d = StResp;
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) state_d = StResp;
            else               cnt_d   = cnt_q - 4'd1;
         end
         StResp: begin
            if (tl_i.d_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         cnt_q        <= 4'd0;
         a_ready_q    <= 1'b0;
         rsp_opcode_q <= AccessAck;
         rsp_size_q   <= 2'd0;
         rsp_source_q <= 8'd0;
         rsp_data_q   <= 32'd0;
         rsp_error_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_ready_q <= (state_d == StIdle);
         if (accept) begin
            rsp_opcode_q <= is_get ? AccessAckData : AccessAck;
            rsp_size_q   <= tl_i.a_size;
            rsp_source_q <= tl_i.a_source;
            rsp_data_q   <= (is_get && !req_err) ? mem[word_idx] : 32'd0;
            rsp_error_q  <= req_err;
         end
      end
   end

   // Memory has no reset; a write committed at its accept edge survives a later reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (tl_i.a_mask[b]) mem[word_idx][8*b +: 8] <= tl_i.a_data[8*b +: 8];
         end
      end
   end

   always_comb begin
      tl_o          = TL_D2H_DEFAULT;
      tl_o.a_ready  = a_ready_q;
      tl_o.d_valid  = (state_q == StResp);
      tl_o.d_opcode = rsp_opcode_q;
      tl_o.d_param  = 3'h0;
      tl_o.d_size   = rsp_size_q;
      tl_o.d_source = rsp_source_q;
      tl_o.d_sink   = 1'b0;
      tl_o.d_data   = rsp_data_q;
      tl_o.d_user   = TL_D_USER_DEFAULT;
      tl_o.d_error  = rsp_error_q;
   end

   assign dbg_state = state_q;
endmodule

// File: tb/tb_tlul_mem_responder.sv
// Directed bench for tlul_mem_responder: one instance with WaitCycles=0, one with WaitCycles=3.
// Expectations for PutPartialData follow TLUL_MEM_PARTIAL_EN.
module tb_tlul_mem_responder;
   import tlul_pkg::*;

`ifdef TLUL_MEM_PARTIAL_EN
   localparam logic [31:0] PartErr  = 32'd0;
   localparam logic [31:0] PartWord = 32'h1122AA44;
`else
   localparam logic [31:0] PartErr  = 32'd1;
   localparam logic [31:0] PartWord = 32'h11223344;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   tl_h2d_t    h2d [2];
   tl_d2h_t    d2h [2];
   logic [1:0] dbg [2];

   tlul_mem_responder #(.Depth(1024), .WaitCycles(0)) u_w0 (
      .clk_i(clk), .rst_ni(rst_n), .tl_i(h2d[0]), .tl_o(d2h[0]), .dbg_state(dbg[0]));
   tlul_mem_responder #(.Depth(1024), .WaitCycles(3)) u_w3 (
      .clk_i(clk), .rst_ni(rst_n), .tl_i(h2d[1]), .tl_o(d2h[1]), .dbg_state(dbg[1]));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_a(input int u, input logic [2:0] op, input logic [31:0] addr,
                          input logic [1:0] sz, input logic [3:0] mask,
                          input logic [31:0] data, input logic [7:0] src, input logic rdy);
      h2d[u].a_valid   = 1'b1;
      h2d[u].a_opcode  = op;
      h2d[u].a_address = addr;
      h2d[u].a_size    = sz;
      h2d[u].a_mask    = mask;
      h2d[u].a_data    = data;
      h2d[u].a_source  = src;
      h2d[u].d_ready   = rdy;
   endtask

   // Issues one request, waits for its response (bounded) and completes the handshake.
   task automatic req(input int u, input logic [2:0] op, input logic [31:0] addr,
                      input logic [1:0] sz, input logic [3:0] mask, input logic [31:0] data,
                      input logic [7:0] src, output tl_d2h_t rsp, output int lat);
      int n;
      n = 0;
      @(negedge clk);
      drive_a(u, op, addr, sz, mask, data, src, 1'b1);
      while (!d2h[u].a_ready && n < 16) begin
         @(negedge clk);
         n++;
      end
      chk("a_ready_wait", 32'(d2h[u].a_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      h2d[u].a_valid = 1'b0;
      lat = 1;
      while (!d2h[u].d_valid && lat < 24) begin
         @(negedge clk);
         lat++;
      end
      rsp = d2h[u];
      @(posedge clk);
   endtask

   tl_d2h_t rsp, held;
   int      lat, n;

   initial begin
      rst_n = 1'b0;
      h2d[0] = '0;
      h2d[1] = '0;
      repeat (2) @(negedge clk);
      chk("rst_a_ready_w0", 32'(d2h[0].a_ready), 32'd0);
      chk("rst_d_valid_w0", 32'(d2h[0].d_valid), 32'd0);
      chk("rst_a_ready_w3", 32'(d2h[1].a_ready), 32'd0);
      chk("rst_state_w0", 32'(dbg[0]), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("release_a_ready_low", 32'(d2h[0].a_ready), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("release_a_ready_w0", 32'(d2h[0].a_ready), 32'd1);
      chk("release_a_ready_w3", 32'(d2h[1].a_ready), 32'd1);

      // Write then read with no wait states
      req(0, PutFullData, 32'h10, 2'd2, 4'hF, 32'hDEADBEEF, 8'h11, rsp, lat);
      chk("putfull_opcode", 32'(rsp.d_opcode), 32'(AccessAck));
      chk("putfull_error", 32'(rsp.d_error), 32'd0);
      chk("putfull_latency", 32'(lat), 32'd1);
      chk("putfull_source", 32'(rsp.d_source), 32'h11);
      chk("putfull_data", rsp.d_data, 32'd0);
      req(0, Get, 32'h10, 2'd2, 4'h0, 32'd0, 8'h22, rsp, lat);
      chk("get_opcode", 32'(rsp.d_opcode), 32'(AccessAckData));
      chk("get_data", rsp.d_data, 32'hDEADBEEF);
      chk("get_error", 32'(rsp.d_error), 32'd0);
      chk("get_latency", 32'(lat), 32'd1);
      chk("get_source", 32'(rsp.d_source), 32'h22);
      chk("get_size", 32'(rsp.d_size), 32'd2);
      chk("get_param_sink", 32'({rsp.d_param, rsp.d_sink}), 32'd0);

      // Error cases leave memory untouched
      req(0, Get, 32'h1002, 2'd2, 4'hF, 32'd0, 8'h31, rsp, lat);
      chk("err_hiaddr_error", 32'(rsp.d_error), 32'd1);
      chk("err_hiaddr_data", rsp.d_data, 32'd0);
      chk("err_hiaddr_opcode", 32'(rsp.d_opcode), 32'(AccessAckData));
      req(0, Get, 32'h3, 2'd2, 4'hF, 32'd0, 8'h32, rsp, lat);
      chk("err_misalign_error", 32'(rsp.d_error), 32'd1);
      req(0, PutFullData, 32'h10, 2'd2, 4'h3, 32'h0, 8'h33, rsp, lat);
      chk("err_badmask_error", 32'(rsp.d_error), 32'd1);
      req(0, 3'd2, 32'h10, 2'd2, 4'hF, 32'h0, 8'h34, rsp, lat);
      chk("err_badop_error", 32'(rsp.d_error), 32'd1);
      chk("err_badop_opcode", 32'(rsp.d_opcode), 32'(AccessAck));
      req(0, PutFullData, 32'h10, 2'd3, 4'hF, 32'h0, 8'h35, rsp, lat);
      chk("err_size3_error", 32'(rsp.d_error), 32'd1);
      req(0, Get, 32'h10, 2'd2, 4'hF, 32'd0, 8'h36, rsp, lat);
      chk("err_mem_unchanged", rsp.d_data, 32'hDEADBEEF);

      // Byte write then halfword Get returns whole word
      req(0, PutFullData, 32'h13, 2'd0, 4'h8, 32'h77000000, 8'h37, rsp, lat);
      chk("byte_write_error", 32'(rsp.d_error), 32'd0);
      req(0, Get, 32'h12, 2'd1, 4'hC, 32'd0, 8'h38, rsp, lat);
      chk("byte_write_readback", rsp.d_data, 32'h77ADBEEF);
      chk("half_get_size", 32'(rsp.d_size), 32'd1);

      // Partial write
      req(0, PutFullData, 32'h0, 2'd2, 4'hF, 32'h11223344, 8'h41, rsp, lat);
      req(0, PutPartialData, 32'h0, 2'd2, 4'h2, 32'h0000AA00, 8'h42, rsp, lat);
      chk("partial_opcode", 32'(rsp.d_opcode), 32'(AccessAck));
      chk("partial_error", 32'(rsp.d_error), PartErr);
      req(0, Get, 32'h0, 2'd2, 4'hF, 32'd0, 8'h43, rsp, lat);
      chk("partial_readback", rsp.d_data, PartWord);

      // Wait states and backpressure
      req(1, PutFullData, 32'h20, 2'd2, 4'hF, 32'hCAFEF00D, 8'h51, rsp, lat);
      chk("w3_put_latency", 32'(lat), 32'd4);
      chk("w3_put_error", 32'(rsp.d_error), 32'd0);
      @(negedge clk);
      drive_a(1, Get, 32'h20, 2'd2, 4'hF, 32'd0, 8'h52, 1'b0);
      n = 0;
      while (!d2h[1].a_ready && n < 16) begin
         @(negedge clk);
         n++;
      end
      chk("bp_a_ready_wait", 32'(d2h[1].a_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      h2d[1].a_valid = 1'b0;
      lat = 1;
      while (!d2h[1].d_valid && lat < 24) begin
         chk("bp_a_ready_wait_low", 32'(d2h[1].a_ready), 32'd0);
         @(negedge clk);
         lat++;
      end
      chk("bp_latency", 32'(lat), 32'd4);
      held = d2h[1];
      chk("bp_data", held.d_data, 32'hCAFEF00D);
      chk("bp_opcode", 32'(held.d_opcode), 32'(AccessAckData));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold", 32'(d2h[1] === held), 32'd1);
         chk("bp_a_ready_low", 32'(d2h[1].a_ready), 32'd0);
      end
      h2d[1].d_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_done_d_valid", 32'(d2h[1].d_valid), 32'd0);
      chk("bp_done_a_ready", 32'(d2h[1].a_ready), 32'd1);

      // Reset while a response is pending
      drive_a(0, Get, 32'h10, 2'd2, 4'hF, 32'd0, 8'h61, 1'b0);
      @(posedge clk);
      @(negedge clk);
      h2d[0].a_valid = 1'b0;
      chk("rr_d_valid_before", 32'(d2h[0].d_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rr_d_valid_dropped", 32'(d2h[0].d_valid), 32'd0);
      chk("rr_state_idle", 32'(dbg[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      req(0, Get, 32'h10, 2'd2, 4'hF, 32'd0, 8'h62, rsp, lat);
      chk("rr_get_data", rsp.d_data, 32'h77ADBEEF);
      chk("rr_get_error", 32'(rsp.d_error), 32'd0);
      chk("rr_get_source", 32'(rsp.d_source), 32'h62);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end
endmodule
